// File: rtl/reduce_step_sequencer.sv
// reduce_step_sequencer
// Drives the modular-reduction step unit ITER times for one operand. Each step
// result is fed back as the next step input. The final value is returned on a
// valid/ready output port. Every output comes straight from a flop. The step
// unit acts on the rising edge of step_en, so step_en is held high for two
// cycles to start a step. It is then held low for at least two cycles before
// the next step starts.
module reduce_step_sequencer #(
  parameter int Size    = 3072,
  parameter int ITER    = 29,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [Size-1:0] in_a,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [Size-1:0] out_a,
  output logic            busy,
  output logic            err,
  output logic            step_en,
  output logic [Size-1:0] step_a,
  input  logic            step_done,
  input  logic [Size-1:0] step_new_a
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ITER_C   = CNT_W'(ITER);
  // Last WAIT cycle before the timeout counter would reach TIMEOUT.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              ph_q, ph_d;            // second cycle of ISSUE / GAP
  logic [CNT_W-1:0]  iter_q, iter_d;
  logic [CNT_W-1:0]  tmo_q, tmo_d;
  logic [Size-1:0]   step_a_q, step_a_d;
  logic [Size-1:0]   out_a_q, out_a_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              step_en_q, step_en_d;

  // Next-state, counter and data-path decisions. The status outputs are
  // decoded from the next state, so that each registered output already
  // matches the state it describes.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    iter_d   = iter_q;
    tmo_d    = tmo_q;
    step_a_d = step_a_q;
    out_a_d  = out_a_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          step_a_d = in_a;
          iter_d   = '0;
          tmo_d    = '0;
          ph_d     = 1'b0;
          err_d    = 1'b0;
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (ph_q) begin
          ph_d    = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end else begin
          ph_d    = 1'b1;
        end
      end
      S_WAIT: begin
        // A done pulse wins over a timeout that expires in the same cycle.
        if (step_done) begin
          step_a_d = step_new_a;
          iter_d   = iter_q + CNT_ONE;
          tmo_d    = '0;
          if ((iter_q + CNT_ONE) == ITER_C) begin
            out_a_d = step_new_a;
            state_d = S_DONE;
          end else begin
            ph_d    = 1'b0;
            state_d = S_GAP;
          end
        end else if (tmo_q == TMO_LAST) begin
          // The step is treated as lost. The partial value is returned with
          // err set.
          err_d   = 1'b1;
          out_a_d = step_a_q;
          tmo_d   = '0;
          state_d = S_DONE;
        end else begin
          tmo_d   = tmo_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (ph_q) begin
          ph_d    = 1'b0;
          state_d = S_ISSUE;
        end else begin
          ph_d    = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ph_d    = 1'b0;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
    step_en_d   = (state_d == S_ISSUE);
  end

  // State, counter, data and output registers. Reset returns to IDLE at once
  // and discards any operand that is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ph_q        <= 1'b0;
      iter_q      <= '0;
      tmo_q       <= '0;
      step_a_q    <= '0;
      out_a_q     <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      step_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      iter_q      <= iter_d;
      tmo_q       <= tmo_d;
      step_a_q    <= step_a_d;
      out_a_q     <= out_a_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      step_en_q   <= step_en_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign step_en   = step_en_q;
  assign step_a    = step_a_q;

endmodule

// File: tb/tb_reduce_step_sequencer.sv
// Directed bench for reduce_step_sequencer with ITER=3 and TIMEOUT=64.
// A behavioural step unit (new_a = a + 1) answers a configurable number of
// cycles after each step_en rising edge. It can stay silent to force a
// timeout, or add stray done pulses outside WAIT.
module tb_reduce_step_sequencer;

  localparam int SZ = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SZ-1:0] in_a;
  logic          out_valid;
  logic          out_ready;
  logic [SZ-1:0] out_a;
  logic          busy;
  logic          err;
  logic          step_en;
  logic [SZ-1:0] step_a;
  logic          step_done;
  logic [SZ-1:0] step_new_a;

  int checks = 0;
  int errors = 0;

  // step unit model controls
  int   model_delay;
  logic model_never;
  logic model_spur;

  reduce_step_sequencer #(
    .Size(SZ), .ITER(3), .TIMEOUT(64), .CNT_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .busy(busy), .err(err),
    .step_en(step_en), .step_a(step_a),
    .step_done(step_done), .step_new_a(step_new_a)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Step unit model. It detects the rising edge of step_en and then pulses
  // done so that the pulse is sampled in WAIT cycle number model_delay.
  int   mdl_cnt;
  logic mdl_prev;
  logic spur_pend;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_prev   <= 1'b0;
      mdl_cnt    <= 0;
      step_done  <= 1'b0;
      spur_pend  <= 1'b0;
      step_new_a <= '0;
    end else begin
      mdl_prev   <= step_en;
      step_done  <= 1'b0;
      step_new_a <= step_a + 32'd1;
      if (step_en && !mdl_prev) begin
        mdl_cnt <= model_delay;
        if (model_spur) step_done <= 1'b1;      // sampled during ISSUE
      end else if (mdl_cnt > 0) begin
        mdl_cnt <= mdl_cnt - 1;
        if (mdl_cnt == 1 && !model_never) begin
          step_done <= 1'b1;
          spur_pend <= model_spur;
        end
      end else if (spur_pend) begin
        step_done <= 1'b1;                      // sampled during GAP / DONE
        spur_pend <= 1'b0;
      end
    end
  end

  // step_en waveform monitor
  int   rises = 0;
  int   hi_run = 0;
  int   lo_run = 0;
  int   lo_last = 0;
  int   hi_bad = 0;
  logic en_prev = 1'b0;
  always @(negedge clk) begin
    if (step_en) begin
      if (!en_prev) begin
        rises++;
        lo_last = lo_run;
        hi_run = 1;
      end else begin
        hi_run++;
      end
    end else begin
      if (en_prev) begin
        if (hi_run != 2) hi_bad++;
        lo_run = 1;
      end else begin
        lo_run++;
      end
    end
    en_prev = step_en;
  end

  // Offer an operand and return at the negedge after the accepting edge.
  task automatic send(input logic [SZ-1:0] a);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("send_ready", 64'd0, 64'd1);
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = 32'hA5A5_5A5A;   // later changes must have no effect
  endtask

  // Count the edges from acceptance until out_valid rises.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 400);
    if (!out_valid) check_eq("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=stuck exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r0;
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; out_ready = 1'b0;
    model_delay = 11; model_never = 1'b0; model_spur = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_a", out_a, 32'd0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_step_en", step_en, 1'b0);
    check_eq("rst_step_a", step_a, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_in_ready", in_ready, 1'b1);

    // Basic run: 5 -> 8. Each step takes 15 cycles and the last step has no
    // GAP, so the latency is 43.
    r0 = rises;
    send(32'd5);
    check_eq("busy_after_accept", busy, 1'b1);
    wait_result(lat);
    check_eq("t1_latency", lat, 43);
    check_eq("t1_out_a", out_a, 32'd8);
    check_eq("t1_err", err, 1'b0);
    check_eq("t1_rises", rises - r0, 3);
    check_eq("t1_low_gap", lo_last, 13);
    take();
    check_eq("t1_released", out_valid, 1'b0);

    // Backpressure: the result holds steady for 20 cycles.
    send(32'd5);
    wait_result(lat);
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (!out_valid || out_a != 32'd8 || in_ready) bad++;
    end
    check_eq("t2_hold_stable", bad, 0);
    // out_ready and in_valid arrive in the same cycle: there is no accept.
    in_valid = 1'b1; in_a = 32'd99; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("t2_not_taken_busy", busy, 1'b0);
    check_eq("t2_not_taken_step_en", step_en, 1'b0);
    check_eq("t2_ready_now", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("t2_taken_next", step_en, 1'b1);
    wait_result(lat);
    check_eq("t2_out_a", out_a, 32'd102);
    take();

    // Timeout: err is set 64 cycles into the first WAIT.
    model_never = 1'b1;
    send(32'd7);
    wait_result(lat);
    check_eq("t3_tmo_latency", lat, 66);
    check_eq("t3_err", err, 1'b1);
    check_eq("t3_out_a", out_a, 32'd7);
    take();
    check_eq("t3_err_sticky", err, 1'b1);
    model_never = 1'b0;
    send(32'd0);
    check_eq("t3_err_cleared", err, 1'b0);
    wait_result(lat);
    check_eq("t3_next_out_a", out_a, 32'd3);
    take();

    // Done arrives in WAIT cycle 64, the same cycle as the timeout: done wins.
    model_delay = 64;
    send(32'd20);
    wait_result(lat);
    check_eq("t4_latency", lat, 202);
    check_eq("t4_err", err, 1'b0);
    check_eq("t4_out_a", out_a, 32'd23);
    take();
    model_delay = 11;

    // Stray done pulses in ISSUE and GAP are ignored.
    model_spur = 1'b1;
    r0 = rises;
    send(32'd5);
    wait_result(lat);
    check_eq("t5_out_a", out_a, 32'd8);
    check_eq("t5_rises", rises - r0, 3);
    check_eq("t5_latency", lat, 43);
    take();
    model_spur = 1'b0;

    // Reset during the WAIT of step 2, then run a fresh operand.
    send(32'd10);
    repeat (19) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("t6_step_en", step_en, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    check_eq("t6_out_valid", out_valid, 1'b0);
    check_eq("t6_step_a", step_a, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(32'd10);
    wait_result(lat);
    check_eq("t6_out_a", out_a, 32'd13);
    check_eq("t6_err", err, 1'b0);
    take();

    check_eq("step_en_high_two", hi_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
